read_mem_arbiter: RTL and testbench
===================================

// Module: read_mem_arbiter
// PURPOSE
//  Shares one combinational byte-lane read memory between 2 requesters. Each requester asks for a
//  burst of 32-bit words. The block arbitrates round-robin, drives the memory byte address, and packs
//  the 4 returned byte lanes into one 32-bit word. Words are returned over a valid/ready stream
//  tagged with the requester id. Sits between compute engines and the read-only data memory.
// PARAMETERS
//  NO_BITS    16  memory byte-address width (same as the memory's addr port)
//  BURST_BITS 4   width of burst_len; a burst is burst_len+1 words (1..16)
// PORTS
//  clk         in   1                 clock, rising edge
//  rst_n       in   1                 asynchronous, active-low reset
//  req         in   2                 per-requester request; level, held until matching done pulse
//  base_addr0  in   NO_BITS           requester 0 start byte address (bits [1:0] ignored)
//  base_addr1  in   NO_BITS           requester 1 start byte address (bits [1:0] ignored)
//  burst_len0  in   BURST_BITS        requester 0 word count minus 1
//  burst_len1  in   BURST_BITS        requester 1 word count minus 1
//  gnt         out  2                 one-hot: requester currently owning the memory
//  done        out  2                 1-cycle pulse per requester when its last word is accepted
//  mem_addr    out  NO_BITS           byte address to memory; registered
//  mem_data    in   [7:0] x [0:3]     memory byte lanes; lane 0 = word bits 31:24
//  rsp_valid   out  1                 rsp_data holds a word
//  rsp_ready   in   1                 consumer accepts the word when valid && ready
//  rsp_id      out  1                 requester the word belongs to
//  rsp_data    out  32                {lane0,lane1,lane2,lane3}
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, rr pointer=0 (req0 favoured).
//    All outputs drop to 0: gnt, done, mem_addr, rsp_valid, rsp_id, rsp_data.
//  - FSM states:
//    IDLE  -> GRANT when |req.
//             Winner: req[ptr] if set, else the other requester.
//             The winner's base_addr is latched with [1:0] forced to 00; burst_len is latched into cnt.
//             gnt is set and mem_addr <= base. ptr <= ~winner.
//    GRANT -> BURST after 1 cycle (memory settles on the registered mem_addr).
//    BURST: a beat loads when !rsp_valid || rsp_ready.
//             On a beat: rsp_data <= packed mem_data, rsp_valid <= 1, rsp_id <= winner,
//             mem_addr <= mem_addr+4, cnt <= cnt-1.
//             The beat with cnt==0 -> DRAIN. No beat while rsp_valid && !rsp_ready (output held stable).
//    DRAIN: on rsp_valid && rsp_ready: rsp_valid <= 0, done[winner] pulses 1 cycle,
//             gnt <= 0 -> IDLE.
//  - Throughput: 1 word/cycle with rsp_ready tied high.
//    First word is valid 2 cycles after the IDLE grant edge.
//  - rsp_valid never drops without handshake; rsp_data/rsp_id are stable while valid && !ready.
//  - mem_addr wraps modulo 2^NO_BITS. Wrap is not an error.
//  - req, base and len are sampled only in IDLE; changes during a burst are ignored.
//  - A requester that drops req mid-burst still receives its full burst.
//  - Both req high: the ptr side wins. After a grant, the other side has priority, so back-to-back
//    requests alternate 0,1,0,1.
//  - A requester re-asserting req on the cycle after its done competes normally (IDLE takes 1 cycle).
//  - Reset mid-burst aborts immediately: no done pulse, the partial burst is discarded.
// STRUCTURE
//  - Package read_mem_pkg:
//      typedef enum logic [1:0] {IDLE, GRANT, BURST, DRAIN} rd_state_t;
//      localparam NUM_REQ=2, WORD_BYTES=4
//      function pack_lanes(): byte lanes -> 32-bit word
//  - Sub-module rr_arbiter2: req[1:0], ptr, update -> one-hot grant, next ptr (combinational + ptr reg).
//  - Top holds the FSM, address/count registers and the output register.
// TESTING (bench instantiates the memory with word i = 32'hA0000000+i)
//  1. Reset: rst_n low mid-burst -> all outputs 0 within the same cycle.
//     After release, req=01 -> gnt=01.
//  2. req0 alone, base=0x0010, len=2, ready=1:
//     rsp_data = A0000004, A0000005, A0000006 on consecutive cycles, id=0; done[0] pulses once.
//  3. req=11 from reset, both len=0:
//     req0 is served first, then req1. Repeat -> order 0,1 again (ptr alternation verified).
//  4. Backpressure: len=3, rsp_ready toggled 1,0,0,1,...
//     All 4 words arrive in order, none dropped or duplicated; data is stable while stalled.
//  5. Wrap: NO_BITS=16, base=0xFFFC, len=1 -> words at byte 0xFFFC then 0x0000;
//     mem_addr returns to 0x0000.
//  6. Unaligned base=0x0013, len=0 -> word index 4 (A0000004) returned.

Source files
------------

// File: rtl/read_mem_pkg.sv
// Shared types and helpers for the two-requester burst read arbiter.
package read_mem_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, BURST, DRAIN} rd_state_t;

  localparam int NUM_REQ    = 2;
  localparam int WORD_BYTES = 4;

  // Lane 0 is the most significant byte of the returned word.
  function automatic logic [31:0] pack_lanes(input logic [7:0] lane0, input logic [7:0] lane1,
                                             input logic [7:0] lane2, input logic [7:0] lane3);
    return {lane0, lane1, lane2, lane3};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant plus a priority pointer
// that hands priority to the loser whenever a grant is taken.
module rr_arbiter2
  import read_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] gnt
);

  logic r_ptr;
  logic w_winner;

  always_comb begin
    w_winner = req[r_ptr] ? r_ptr : ~r_ptr;
    gnt      = '0;
    if (|req) gnt[w_winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (update && (|req)) begin
      r_ptr <= ~w_winner;
    end
  end

endmodule

// File: rtl/read_mem_arbiter.sv
// Shares a combinational byte-lane read memory between two burst requesters and
// returns packed 32-bit words over a valid/ready stream tagged with the requester id.
module read_mem_arbiter
  import read_mem_pkg::*;
#(
  parameter int NO_BITS    = 16,
  parameter int BURST_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NO_BITS-1:0]    base_addr0,
  input  logic [NO_BITS-1:0]    base_addr1,
  input  logic [BURST_BITS-1:0] burst_len0,
  input  logic [BURST_BITS-1:0] burst_len1,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [NO_BITS-1:0]    mem_addr,
  input  logic [7:0]            mem_data [0:WORD_BYTES-1],
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [31:0]           rsp_data
);

  localparam logic [NO_BITS-1:0] ALIGN_MASK = ~NO_BITS'(WORD_BYTES - 1);
  localparam logic [NO_BITS-1:0] ADDR_STEP  = NO_BITS'(WORD_BYTES);

  rd_state_t             r_state;
  logic                  r_winner;
  logic [BURST_BITS-1:0] r_cnt;
  logic [NO_BITS-1:0]    r_mem_addr;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [NUM_REQ-1:0]    r_done;
  logic                  r_rsp_valid;
  logic                  r_rsp_id;
  logic [31:0]           r_rsp_data;

  logic [NUM_REQ-1:0]    w_arb_gnt;
  logic                  w_arb_id;
  logic                  w_idle_take;
  logic                  w_beat;

  assign w_idle_take = (r_state == IDLE) && (|req);
  assign w_arb_id    = w_arb_gnt[1];
  // A new beat may overwrite the output register only once the held word is gone.
  assign w_beat      = (r_state == BURST) && (!r_rsp_valid || rsp_ready);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .update (w_idle_take),
    .gnt    (w_arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_winner    <= 1'b0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_idle_take) begin
            r_winner   <= w_arb_id;
            r_gnt      <= w_arb_gnt;
            r_mem_addr <= (w_arb_id ? base_addr1 : base_addr0) & ALIGN_MASK;
            r_cnt      <= w_arb_id ? burst_len1 : burst_len0;
            r_state    <= GRANT;
          end
        end
        GRANT: r_state <= BURST;
        BURST: begin
          if (w_beat) begin
            r_rsp_data  <= pack_lanes(mem_data[0], mem_data[1], mem_data[2], mem_data[3]);
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_winner;
            r_mem_addr  <= r_mem_addr + ADDR_STEP;
            r_cnt       <= r_cnt - BURST_BITS'(1);
            if (r_cnt == '0) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid      <= 1'b0;
            r_done[r_winner] <= 1'b1;
            r_gnt            <= '0;
            r_state          <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign mem_addr  = r_mem_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_read_mem_arbiter.sv
// Bench for read_mem_arbiter: hand sequences for reset/wrap timing, a vector table of
// bursts, then random bursts scored against a transaction-level model of the memory.
module tb_read_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] base_addr0, base_addr1;
  logic [3:0]  burst_len0, burst_len1;
  logic [1:0]  gnt, done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data [0:3];
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;

  int nChecks = 0;
  int nFails  = 0;
  int mPtr    = 0;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } word_t;

  typedef struct {
    logic        doReset;
    logic [1:0]  mask;
    logic [15:0] b0;
    logic [15:0] b1;
    logic [3:0]  l0;
    logic [3:0]  l1;
    int          readyMode;
    logic        expFirstId;
    logic [31:0] expFirstData;
  } vec_t;

  word_t expQ[$];
  word_t gotQ[$];
  int    gotCyc[$];
  vec_t  vecs [7];

  always #5 clk = ~clk;

  // Memory word i holds A0000000+i; byte address selects the word by its upper bits.
  logic [31:0] memWord;
  always_comb begin
    memWord = 32'hA000_0000 + 32'(mem_addr >> 2);
    for (int k = 0; k < 4; k++) mem_data[k] = memWord[31-8*k -: 8];
  end

  read_mem_arbiter #(.NO_BITS(16), .BURST_BITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .base_addr0 (base_addr0),
    .base_addr1 (base_addr1),
    .burst_len0 (burst_len0),
    .burst_len1 (burst_len1),
    .gnt        (gnt),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [15:0] b0, input logic [15:0] b1,
                               input logic [3:0] l0, input logic [3:0] l1, input logic rdy);
    req        = m;
    base_addr0 = b0;
    base_addr1 = b1;
    burst_len0 = l0;
    burst_len1 = l1;
    rsp_ready  = rdy;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(2'b00, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mPtr  = 0;
  endtask

  // Service order from the arbitration rules; each burst reads consecutive memory words.
  task automatic modelSession(input logic [1:0] mask, input logic [15:0] b0, input logic [15:0] b1,
                              input logic [3:0] l0, input logic [3:0] l1);
    logic [1:0]  pend;
    int          w;
    int          n;
    logic [15:0] b;
    pend = mask;
    while (pend != 2'b00) begin
      w = pend[mPtr] ? mPtr : 1 - mPtr;
      b = (w == 1) ? b1 : b0;
      n = ((w == 1) ? int'(l1) : int'(l0)) + 1;
      for (int k = 0; k < n; k++)
        expQ.push_back('{id: (w == 1), data: 32'hA000_0000 + 32'((int'(b) / 4 + k) % 16384)});
      mPtr    = 1 - w;
      pend[w] = 1'b0;
    end
  endtask

  task automatic runSession(input string tag, input logic [1:0] mask, input logic [15:0] b0,
                            input logic [15:0] b1, input logic [3:0] l0, input logic [3:0] l1,
                            input int readyMode, input int maxCycles);
    logic [1:0]  pend;
    int          doneCnt [2];
    int          cyc;
    logic        prevStall;
    logic        prevId;
    logic [31:0] prevData;
    logic        rdy;
    expQ.delete();
    gotQ.delete();
    gotCyc.delete();
    modelSession(mask, b0, b1, l0, l1);
    pend       = mask;
    doneCnt[0] = 0;
    doneCnt[1] = 0;
    cyc        = 0;
    prevStall  = 1'b0;
    prevId     = 1'b0;
    prevData   = '0;
    applyStimulus(mask, b0, b1, l0, l1, 1'b1);
    while ((pend != 2'b00) && (cyc < maxCycles)) begin
      @(negedge clk);
      cyc++;
      for (int r = 0; r < 2; r++) begin
        if (done[r]) begin
          doneCnt[r]++;
          pend[r] = 1'b0;
        end
      end
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 1) || ((cyc % 4) == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      req       = pend;
      rsp_ready = rdy;
      #1;
      if (prevStall)
        checkOutput({tag, " stall hold"}, {30'b0, rsp_valid, rsp_id, rsp_data}, {30'b0, 1'b1, prevId, prevData});
      if (rsp_valid && rsp_ready) begin
        gotQ.push_back('{id: rsp_id, data: rsp_data});
        gotCyc.push_back(cyc);
      end
      prevStall = rsp_valid && !rsp_ready;
      prevId    = rsp_id;
      prevData  = rsp_data;
    end
    req = 2'b00;
    checkOutput({tag, " all done seen"}, 64'(pend), 64'd0);
    for (int r = 0; r < 2; r++)
      checkOutput($sformatf("%s done count %0d", tag, r), 64'(doneCnt[r]), 64'(mask[r]));
    checkOutput({tag, " word count"}, 64'(gotQ.size()), 64'(expQ.size()));
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
      checkOutput($sformatf("%s word %0d", tag, i), {31'b0, gotQ[i].id, gotQ[i].data},
                  {31'b0, expQ[i].id, expQ[i].data});
    if (readyMode == 0 && mask != 2'b11 && gotCyc.size() > 0)
      checkOutput({tag, " back-to-back"}, 64'(gotCyc[gotCyc.size()-1] - gotCyc[0]), 64'(gotCyc.size() - 1));
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'b01, 16'h0010, 16'h0000, 4'd2, 4'd0, 0, 1'b0, 32'hA000_0004};
    vecs[1] = '{1'b1, 2'b11, 16'h0000, 16'h0040, 4'd0, 4'd0, 0, 1'b0, 32'hA000_0000};
    vecs[2] = '{1'b0, 2'b11, 16'h0000, 16'h0040, 4'd0, 4'd0, 0, 1'b0, 32'hA000_0000};
    vecs[3] = '{1'b0, 2'b01, 16'h0020, 16'h0000, 4'd3, 4'd0, 1, 1'b0, 32'hA000_0008};
    vecs[4] = '{1'b0, 2'b01, 16'h0013, 16'h0000, 4'd0, 4'd0, 0, 1'b0, 32'hA000_0004};
    vecs[5] = '{1'b0, 2'b10, 16'h0000, 16'h0100, 4'd0, 4'd5, 2, 1'b1, 32'hA000_0040};
    vecs[6] = '{1'b0, 2'b11, 16'h0200, 16'h0300, 4'd1, 4'd2, 2, 1'b0, 32'hA000_0080};

    rst_n = 1'b1;
    applyStimulus(2'b00, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset state", {10'b0, gnt, done, mem_addr, rsp_valid, rsp_id, rsp_data}, 64'd0);
    rst_n = 1'b1;
    mPtr  = 0;

    // Wrap burst: also pins first-word latency and single-cycle beats.
    @(negedge clk);
    applyStimulus(2'b01, 16'hFFFC, 16'h0000, 4'd1, 4'd0, 1'b1);
    @(negedge clk);
    checkOutput("wrap grant", {gnt, mem_addr, rsp_valid}, {2'b01, 16'hFFFC, 1'b0});
    @(negedge clk);
    checkOutput("wrap settle", {rsp_valid, mem_addr}, {1'b0, 16'hFFFC});
    @(negedge clk);
    checkOutput("wrap beat0", {rsp_valid, rsp_id, rsp_data, mem_addr}, {1'b1, 1'b0, 32'hA000_3FFF, 16'h0000});
    @(negedge clk);
    checkOutput("wrap beat1", {rsp_valid, rsp_data, done}, {1'b1, 32'hA000_0000, 2'b00});
    @(negedge clk);
    checkOutput("wrap done", {done, gnt, rsp_valid}, {2'b01, 2'b00, 1'b0});
    req = 2'b00;
    @(negedge clk);
    checkOutput("wrap done single", 64'(done), 64'd0);
    mPtr = 1;

    // Reset in the middle of a long burst.
    applyStimulus(2'b01, 16'h0000, 16'h0000, 4'd15, 4'd0, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("pre-reset busy", 64'(rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 checkOutput("reset mid-burst", {10'b0, gnt, done, mem_addr, rsp_valid, rsp_id, rsp_data}, 64'd0);
    @(negedge clk);
    checkOutput("reset held", {10'b0, gnt, done, mem_addr, rsp_valid, rsp_id, rsp_data}, 64'd0);
    rst_n = 1'b1;
    mPtr  = 0;
    applyStimulus(2'b01, 16'h0040, 16'h0000, 4'd0, 4'd0, 1'b1);
    @(negedge clk);
    checkOutput("post-reset grant", 64'(gnt), 64'h1);
    begin
      int guard;
      guard = 0;
      while (!done[0] && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      checkOutput("post-reset done", 64'(done), 64'h1);
      req  = 2'b00;
      mPtr = 1;
    end

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].doReset) doReset();
      runSession($sformatf("vec%0d", v), vecs[v].mask, vecs[v].b0, vecs[v].b1,
                 vecs[v].l0, vecs[v].l1, vecs[v].readyMode, 200);
      if (gotQ.size() > 0)
        checkOutput($sformatf("vec%0d first", v), {31'b0, gotQ[0].id, gotQ[0].data},
                    {31'b0, vecs[v].expFirstId, vecs[v].expFirstData});
      else
        checkOutput($sformatf("vec%0d first present", v), 64'd0, 64'd1);
    end

    for (int i = 0; i < 25; i++) begin
      runSession($sformatf("rand%0d", i), 2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
